// File: rtl/challenge_auth_engine.sv
// CHALLENGE responder: validates one decoded request and streams either a
// CHALLENGE_AUTH or an ERROR response byte-serially to the transmit buffer.
module challenge_auth_engine #(
  parameter int unsigned NUM_SLOTS        = 8,
  parameter int unsigned HASH_BYTES       = 32,
  parameter int unsigned NONCE_BYTES      = 32,
  parameter logic [7:0]  PROTOCOL_VERSION = 8'h01,
  parameter logic [7:0]  CAPABILITIES     = 8'h01
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [31:0]                       req_header_i,
  input  logic [NONCE_BYTES*8-1:0]          req_nonce_i,
  input  logic [NUM_SLOTS*HASH_BYTES*8-1:0] slot_hash_i,
  input  logic [NUM_SLOTS-1:0]              slot_populated_i,
  output logic                              tx_valid_o,
  input  logic                              tx_ready_i,
  output logic [7:0]                        tx_data_o,
  output logic                              tx_last_o,
  output logic                              tx_is_error_o,
  output logic [7:0]                        err_count_o
);
  localparam int unsigned HASH_W        = HASH_BYTES * 8;
  localparam int unsigned NONCE_W       = NONCE_BYTES * 8;
  localparam int unsigned VALID_LEN     = 8 + HASH_BYTES + NONCE_BYTES;
  localparam int unsigned ERR_LEN       = 4;
  localparam int unsigned IDX_W         = $clog2(VALID_LEN);
  localparam logic [7:0]  MSG_CHALLENGE = 8'h83;

  typedef enum logic [1:0] {IDLE, CHECK, SEND} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, nxt_idx_c, last_idx_c;
  logic               req_ready_q;
  logic               tx_valid_q, tx_valid_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_last_q, tx_last_d;
  logic               tx_is_err_q, tx_is_err_d;
  logic [7:0]         err_code_q, err_code_d;
  logic [7:0]         err_count_q, err_count_d;
  logic [7:0]         ver_q, type_q, slot_q;
  logic [NUM_SLOTS-1:0] pop_q;
  logic [HASH_W-1:0]  hash_q, sel_hash_c;
  logic [NONCE_W-1:0] nonce_q;
  logic               accept_c, slot_ok_c;
  logic [7:0]         byte_c;
  logic               param2_unused;

  assign param2_unused = ^req_header_i[7:0];
  assign accept_c      = req_valid_i && req_ready_q;

  // Hash of the requested slot; out-of-range slots select all zeros
  always_comb begin
    sel_hash_c = '0;
    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      if (req_header_i[15:8] == 8'(s)) sel_hash_c = slot_hash_i[s*HASH_W +: HASH_W];
    end
  end

  // Range is checked before the population bit is looked at
  always_comb begin
    slot_ok_c = 1'b0;
    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      if (slot_q == 8'(s)) slot_ok_c = pop_q[s];
    end
    slot_ok_c = (slot_q < 8'(NUM_SLOTS)) && slot_ok_c;
  end

  // Byte that follows the one currently presented
  always_comb begin
    nxt_idx_c  = idx_q + IDX_W'(1);
    last_idx_c = tx_is_err_q ? IDX_W'(ERR_LEN - 1) : IDX_W'(VALID_LEN - 1);
    byte_c     = 8'h00;
    if (tx_is_err_q) begin
      if (nxt_idx_c == IDX_W'(1))      byte_c = 8'h7F;
      else if (nxt_idx_c == IDX_W'(2)) byte_c = err_code_q;
    end else if (32'(nxt_idx_c) < 32'd8) begin
      case (nxt_idx_c[2:0])
        3'd0:    byte_c = PROTOCOL_VERSION;
        3'd1:    byte_c = 8'h03;
        3'd2:    byte_c = slot_q;
        3'd3:    byte_c = 8'(pop_q);
        3'd4:    byte_c = PROTOCOL_VERSION;
        3'd5:    byte_c = PROTOCOL_VERSION;
        3'd6:    byte_c = CAPABILITIES;
        default: byte_c = 8'h00;
      endcase
    end else if (32'(nxt_idx_c) < 32'(8 + HASH_BYTES)) begin
      byte_c = 8'(hash_q >> (8 * (32'(8 + HASH_BYTES - 1) - 32'(nxt_idx_c))));
    end else begin
      byte_c = 8'(nonce_q >> (8 * (32'(VALID_LEN - 1) - 32'(nxt_idx_c))));
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    tx_last_d   = tx_last_q;
    tx_is_err_d = tx_is_err_q;
    err_code_d  = err_code_q;
    err_count_d = err_count_q;
    case (state_q)
      IDLE: begin
        if (accept_c) state_d = CHECK;
      end
      CHECK: begin
        state_d    = SEND;
        idx_d      = '0;
        tx_valid_d = 1'b1;
        tx_data_d  = PROTOCOL_VERSION;
        tx_last_d  = 1'b0;
        if (ver_q != PROTOCOL_VERSION) begin
          err_code_d  = 8'h02;
          tx_is_err_d = 1'b1;
        end else if (type_q != MSG_CHALLENGE || !slot_ok_c) begin
          err_code_d  = 8'h01;
          tx_is_err_d = 1'b1;
        end else begin
          err_code_d  = 8'h00;
          tx_is_err_d = 1'b0;
        end
      end
      SEND: begin
        if (tx_ready_i) begin
          if (tx_last_q) begin
            state_d     = IDLE;
            tx_valid_d  = 1'b0;
            tx_data_d   = 8'h00;
            tx_last_d   = 1'b0;
            tx_is_err_d = 1'b0;
            if (tx_is_err_q && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
          end else begin
            idx_d     = nxt_idx_c;
            tx_data_d = byte_c;
            tx_last_d = (nxt_idx_c == last_idx_c);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      req_ready_q <= 1'b1;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_last_q   <= 1'b0;
      tx_is_err_q <= 1'b0;
      err_code_q  <= 8'h00;
      err_count_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      req_ready_q <= (state_d == IDLE);
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      tx_last_q   <= tx_last_d;
      tx_is_err_q <= tx_is_err_d;
      err_code_q  <= err_code_d;
      err_count_q <= err_count_d;
    end
  end

  // Request snapshot; later input changes cannot disturb the message
  always_ff @(posedge clk_i) begin
    if (accept_c) begin
      ver_q   <= req_header_i[31:24];
      type_q  <= req_header_i[23:16];
      slot_q  <= req_header_i[15:8];
      pop_q   <= slot_populated_i;
      hash_q  <= sel_hash_c;
      nonce_q <= req_nonce_i;
    end
  end

  assign req_ready_o   = req_ready_q;
  assign tx_valid_o    = tx_valid_q;
  assign tx_data_o     = tx_data_q;
  assign tx_last_o     = tx_last_q;
  assign tx_is_error_o = tx_is_err_q;
  assign err_count_o   = err_count_q;
endmodule

// File: tb/tb_challenge_auth_engine.sv
// Directed bench for challenge_auth_engine: valid, error, backpressure,
// back-to-back, mid-message reset and error-counter saturation scenarios.
module tb_challenge_auth_engine;
  localparam int unsigned NS   = 8;
  localparam int unsigned HB   = 32;
  localparam int unsigned NB   = 32;
  localparam int unsigned VLEN = 8 + HB + NB;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [31:0]      req_header = '0;
  logic [NB*8-1:0]  req_nonce = '0;
  logic [NS*HB*8-1:0] slot_hash = '0;
  logic [NS-1:0]    slot_populated = '0;
  logic             tx_valid;
  logic             tx_ready = 1'b1;
  logic [7:0]       tx_data;
  logic             tx_last;
  logic             tx_is_error;
  logic [7:0]       err_count;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_b [0:127];
  int         exp_n;
  logic       exp_err;
  logic [7:0] rx_data [0:127];
  logic       rx_err [0:127];
  logic       rx_last [0:127];
  int rx_n, rx_cycles, last_cnt, stall_viol, vdrop, rr_high;
  bit rx_timeout;
  logic [7:0] lfsr = 8'hA7;

  always #5 clk = ~clk;

  challenge_auth_engine #(
    .NUM_SLOTS(NS), .HASH_BYTES(HB), .NONCE_BYTES(NB),
    .PROTOCOL_VERSION(8'h01), .CAPABILITIES(8'h01)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_header_i(req_header), .req_nonce_i(req_nonce),
    .slot_hash_i(slot_hash), .slot_populated_i(slot_populated),
    .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tx_data_o(tx_data),
    .tx_last_o(tx_last), .tx_is_error_o(tx_is_error), .err_count_o(err_count)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_hash_slot(input int s, input logic [7:0] base, input logic [7:0] step);
    for (int k = 0; k < HB; k++) slot_hash[(s+1)*HB*8 - 1 - 8*k -: 8] = base + 8'(step * k);
  endtask

  // slot 0 bytes 0x31+3k, slot 2 all 0xA5, others 16*s+k
  task automatic setup_stim();
    for (int s = 0; s < NS; s++) set_hash_slot(s, 8'(16 * s), 8'd1);
    set_hash_slot(0, 8'h31, 8'd3);
    set_hash_slot(2, 8'hA5, 8'd0);
    for (int i = 0; i < NB; i++) req_nonce[NB*8 - 1 - 8*i -: 8] = 8'(i);
  endtask

  task automatic build_valid_exp(input logic [7:0] slot, input logic [7:0] pop,
                                 input logic [7:0] base, input logic [7:0] step);
    exp_b[0] = 8'h01; exp_b[1] = 8'h03; exp_b[2] = slot;  exp_b[3] = pop;
    exp_b[4] = 8'h01; exp_b[5] = 8'h01; exp_b[6] = 8'h01; exp_b[7] = 8'h00;
    for (int k = 0; k < HB; k++) exp_b[8 + k] = base + 8'(step * k);
    for (int i = 0; i < NB; i++) exp_b[8 + HB + i] = 8'(i);
    exp_n   = VLEN;
    exp_err = 1'b0;
  endtask

  task automatic build_err_exp(input logic [7:0] code);
    exp_b[0] = 8'h01; exp_b[1] = 8'h7F; exp_b[2] = code; exp_b[3] = 8'h00;
    exp_n   = 4;
    exp_err = 1'b1;
  endtask

  // Present a request for one cycle; returns in the cycle after acceptance
  task automatic send_req(input logic [31:0] hdr, input logic [NS-1:0] pop);
    req_header     = hdr;
    slot_populated = pop;
    req_valid      = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Collect one message; abort_at >= 0 asserts reset when that byte is presented
  task automatic recv(input bit bp, input int abort_at);
    int cyc;
    bit stalled, done;
    logic [7:0] sd;
    logic sl, se;
    rx_n = 0; rx_cycles = 0; last_cnt = 0; stall_viol = 0; vdrop = 0; rr_high = 0;
    rx_timeout = 1'b0; stalled = 1'b0; done = 1'b0; cyc = 0;
    sd = '0; sl = 1'b0; se = 1'b0;
    while (!done && cyc < 2000) begin
      if (abort_at >= 0 && rx_n == abort_at) begin
        reset = 1'b1;
        done  = 1'b1;
      end else begin
        lfsr     = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        tx_ready = bp ? lfsr[0] : 1'b1;
        if (!tx_valid) vdrop++;
        if (req_ready) rr_high++;
        if (stalled && (tx_data !== sd || tx_last !== sl || tx_is_error !== se)) stall_viol++;
        if (tx_valid && tx_ready) begin
          if (rx_n < 128) begin
            rx_data[rx_n] = tx_data;
            rx_err[rx_n]  = tx_is_error;
            rx_last[rx_n] = tx_last;
          end
          rx_n++;
          if (tx_last) begin
            last_cnt++;
            done = 1'b1;
          end
          rx_cycles = cyc;
          stalled   = 1'b0;
        end else begin
          stalled = 1'b1;
          sd = tx_data; sl = tx_last; se = tx_is_error;
        end
      end
      tick();
      cyc++;
    end
    tx_ready = 1'b1;
    if (!done) rx_timeout = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({req_ready, tx_valid, tx_last, tx_is_error} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy/val/last/err=%b want 1000", {req_ready, tx_valid, tx_last, tx_is_error});
    end
    checks++;
    if (tx_data !== 8'h00 || err_count !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got data=%h cnt=%0d want 00/0", tx_data, err_count);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (req_ready !== 1'b1 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got ready=%b valid=%b want 1/0", req_ready, tx_valid);
    end
  endtask

  task automatic test_valid();
    setup_stim();
    build_valid_exp(8'h02, 8'h05, 8'hA5, 8'h00);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL valid_ready: got %b want 1", req_ready); end
    send_req(32'h01_83_02_00, 8'h05);
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL valid_lat1: got tx_valid=%b want 0", tx_valid); end
    tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin
      errors++;
      $display("FAIL valid_lat2: got valid=%b data=%h want 1/01", tx_valid, tx_data);
    end
    recv(1'b0, -1);
    checks++;
    if (rx_timeout || rx_n != exp_n) begin errors++; $display("FAIL valid_len: got %0d bytes timeout=%0b want %0d", rx_n, rx_timeout, exp_n); end
    for (int i = 0; i < exp_n; i++) begin
      checks++;
      if (rx_data[i] !== exp_b[i] || rx_err[i] !== exp_err) begin
        errors++;
        $display("FAIL valid_byte%0d: got %h err=%b want %h err=%b", i, rx_data[i], rx_err[i], exp_b[i], exp_err);
      end
    end
    checks++;
    if (last_cnt != 1 || rx_last[exp_n-1] !== 1'b1) begin errors++; $display("FAIL valid_last: got count=%0d final=%b want 1/1", last_cnt, rx_last[exp_n-1]); end
    checks++;
    if (rx_cycles != int'(VLEN) - 1 || rr_high != 0) begin
      errors++;
      $display("FAIL valid_timing: got last_cyc=%0d ready_hi=%0d want %0d/0", rx_cycles, rr_high, VLEN - 1);
    end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL valid_ready_after: got %b want 1", req_ready); end
  endtask

  task automatic test_version_err();
    build_err_exp(8'h02);
    send_req(32'h02_83_00_00, 8'h05);
    tick();
    recv(1'b0, -1);
    checks++;
    if (rx_timeout || rx_n != exp_n) begin errors++; $display("FAIL ver_len: got %0d bytes timeout=%0b want %0d", rx_n, rx_timeout, exp_n); end
    for (int i = 0; i < exp_n; i++) begin
      checks++;
      if (rx_data[i] !== exp_b[i] || rx_err[i] !== exp_err) begin
        errors++;
        $display("FAIL ver_byte%0d: got %h err=%b want %h err=%b", i, rx_data[i], rx_err[i], exp_b[i], exp_err);
      end
    end
    checks++;
    if (last_cnt != 1 || rx_last[exp_n-1] !== 1'b1) begin errors++; $display("FAIL ver_last: got count=%0d final=%b want 1/1", last_cnt, rx_last[exp_n-1]); end
    checks++;
    if (err_count !== 8'd1) begin errors++; $display("FAIL ver_cnt: got %0d want 1", err_count); end
  endtask

  task automatic test_slot_err();
    logic [31:0] hdrs [0:2];
    hdrs[0] = 32'h01_83_01_00;
    hdrs[1] = 32'h01_83_09_00;
    hdrs[2] = 32'h01_84_00_00;
    pulse_reset();
    build_err_exp(8'h01);
    for (int n = 0; n < 3; n++) begin
      send_req(hdrs[n], 8'h01);
      tick();
      recv(1'b0, -1);
      checks++;
      if (rx_timeout || rx_n != exp_n) begin errors++; $display("FAIL slot%0d_len: got %0d bytes want %0d", n, rx_n, exp_n); end
      for (int i = 0; i < exp_n; i++) begin
        checks++;
        if (rx_data[i] !== exp_b[i] || rx_err[i] !== exp_err) begin
          errors++;
          $display("FAIL slot%0d_byte%0d: got %h err=%b want %h err=%b", n, i, rx_data[i], rx_err[i], exp_b[i], exp_err);
        end
      end
      checks++;
      if (err_count !== 8'(n + 1)) begin errors++; $display("FAIL slot%0d_cnt: got %0d want %0d", n, err_count, n + 1); end
    end
  endtask

  task automatic test_backpressure();
    setup_stim();
    build_valid_exp(8'h00, 8'h01, 8'h31, 8'h03);
    send_req(32'h01_83_00_00, 8'h01);
    req_header     = 32'hFFFF_FFFF;
    req_nonce      = '1;
    slot_hash      = ~slot_hash;
    slot_populated = '0;
    tick();
    recv(1'b1, -1);
    checks++;
    if (rx_timeout || rx_n != exp_n) begin errors++; $display("FAIL bp_len: got %0d bytes timeout=%0b want %0d", rx_n, rx_timeout, exp_n); end
    for (int i = 0; i < exp_n; i++) begin
      checks++;
      if (rx_data[i] !== exp_b[i] || rx_err[i] !== exp_err) begin
        errors++;
        $display("FAIL bp_byte%0d: got %h err=%b want %h err=%b", i, rx_data[i], rx_err[i], exp_b[i], exp_err);
      end
    end
    checks++;
    if (last_cnt != 1 || rx_last[exp_n-1] !== 1'b1) begin errors++; $display("FAIL bp_last: got count=%0d final=%b want 1/1", last_cnt, rx_last[exp_n-1]); end
    checks++;
    if (stall_viol != 0 || vdrop != 0 || rr_high != 0) begin
      errors++;
      $display("FAIL bp_stable: got stall_changes=%0d valid_drops=%0d ready_hi=%0d want 0/0/0", stall_viol, vdrop, rr_high);
    end
    setup_stim();
  endtask

  task automatic test_back_to_back();
    build_err_exp(8'h02);
    req_header     = 32'h02_83_00_00;
    slot_populated = 8'h05;
    req_valid      = 1'b1;
    tick();
    req_header = 32'h01_83_02_00;
    tick();
    recv(1'b0, -1);
    checks++;
    if (rx_timeout || rx_n != exp_n || rr_high != 0) begin
      errors++;
      $display("FAIL b2b_a_len: got %0d bytes ready_hi=%0d want %0d/0", rx_n, rr_high, exp_n);
    end
    for (int i = 0; i < exp_n; i++) begin
      checks++;
      if (rx_data[i] !== exp_b[i] || rx_err[i] !== exp_err) begin
        errors++;
        $display("FAIL b2b_a_byte%0d: got %h err=%b want %h err=%b", i, rx_data[i], rx_err[i], exp_b[i], exp_err);
      end
    end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    checks++;
    if (tx_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_check: got valid=%b ready=%b want 0/0", tx_valid, req_ready);
    end
    build_valid_exp(8'h02, 8'h05, 8'hA5, 8'h00);
    tick();
    recv(1'b0, -1);
    checks++;
    if (rx_timeout || rx_n != exp_n) begin errors++; $display("FAIL b2b_b_len: got %0d bytes want %0d", rx_n, exp_n); end
    for (int i = 0; i < exp_n; i++) begin
      checks++;
      if (rx_data[i] !== exp_b[i] || rx_err[i] !== exp_err) begin
        errors++;
        $display("FAIL b2b_b_byte%0d: got %h err=%b want %h err=%b", i, rx_data[i], rx_err[i], exp_b[i], exp_err);
      end
    end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    send_req(32'h02_83_00_00, 8'h05);
    tick();
    recv(1'b0, -1);
    checks++;
    if (err_count !== 8'd1) begin errors++; $display("FAIL rmid_pre_cnt: got %0d want 1", err_count); end
    send_req(32'h01_83_02_00, 8'h05);
    tick();
    recv(1'b0, 10);
    reset = 1'b0;
    checks++;
    if (tx_valid !== 1'b0 || tx_last !== 1'b0 || req_ready !== 1'b1 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL rmid_idle: got valid=%b last=%b ready=%b cnt=%0d want 0/0/1/0", tx_valid, tx_last, req_ready, err_count);
    end
    checks++;
    if (rx_n != 10 || last_cnt != 0) begin errors++; $display("FAIL rmid_partial: got %0d bytes lasts=%0d want 10/0", rx_n, last_cnt); end
    build_valid_exp(8'h02, 8'h05, 8'hA5, 8'h00);
    send_req(32'h01_83_02_00, 8'h05);
    tick();
    recv(1'b0, -1);
    checks++;
    if (rx_timeout || rx_n != exp_n) begin errors++; $display("FAIL rmid_len: got %0d bytes want %0d", rx_n, exp_n); end
    for (int i = 0; i < exp_n; i++) begin
      checks++;
      if (rx_data[i] !== exp_b[i] || rx_err[i] !== exp_err) begin
        errors++;
        $display("FAIL rmid_byte%0d: got %h err=%b want %h err=%b", i, rx_data[i], rx_err[i], exp_b[i], exp_err);
      end
    end
    // Reset wins over a simultaneous request
    req_header = 32'h01_83_02_00;
    req_valid  = 1'b1;
    reset      = 1'b1;
    tick();
    reset     = 1'b0;
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rprio_ready: got %b want 1", req_ready); end
    tick();
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL rprio_valid: got %b want 0", tx_valid); end
  endtask

  task automatic test_saturation();
    int tmo;
    tmo = 0;
    pulse_reset();
    for (int n = 1; n <= 260; n++) begin
      send_req(32'h01_83_09_00, 8'h00);
      tick();
      recv(1'b0, -1);
      if (rx_timeout) tmo++;
      if (n == 254 || n == 255 || n == 260) begin
        checks++;
        if (err_count !== 8'(n > 255 ? 255 : n)) begin
          errors++;
          $display("FAIL sat_cnt_after_%0d: got %0d want %0d", n, err_count, n > 255 ? 255 : n);
        end
      end
    end
    checks++;
    if (tmo != 0) begin errors++; $display("FAIL sat_timeout: got %0d timeouts want 0", tmo); end
  endtask

  initial begin
    test_reset();
    test_valid();
    test_version_err();
    test_slot_err();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/challenge_auth_engine.md
# challenge_auth_engine

Parametrised CHALLENGE responder for the USB Type-C authentication responder datapath. It accepts one decoded CHALLENGE request (header plus nonce) and validates the protocol version, message type and requested slot. It then streams either a CHALLENGE_AUTH response or an ERROR response, byte-serially, over a valid/ready interface to the message transmit buffer. It supports a configurable slot count, hash size and nonce size, per-slot population checks, backpressure and error reporting.

## Interface
- NUM_SLOTS, 8, number of certificate slots (1..8)
- HASH_BYTES, 32, cert-chain hash length in bytes
- NONCE_BYTES, 32, nonce length in bytes, echoed in the response
- PROTOCOL_VERSION, 8'h01, supported protocol version
- CAPABILITIES, 8'h01, capabilities byte
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  engine can accept a request
- req_header  in  32  {[31:24] version, [23:16] msg type, [15:8] Param1 = slot, [7:0] Param2}
- req_nonce  in  NONCE_BYTES*8  nonce, byte 0 = MSBs
- slot_hash  in  NUM_SLOTS*HASH_BYTES*8  per-slot cert-chain hashes; slot s occupies bits [(s+1)*HASH_BYTES*8-1 : s*HASH_BYTES*8]
- slot_populated  in  NUM_SLOTS  bit s = slot s holds a chain
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts byte
- tx_data  out  8  response byte
- tx_last  out  1  final byte of the message
- tx_is_error  out  1  current message is an ERROR response
- err_count  out  8  saturating count of ERROR responses sent

## Operation
- States: IDLE, CHECK, SEND.
- req_ready = 1 only in IDLE.
- In IDLE, the request handshake req_valid && req_ready latches req_header, req_nonce and the hash of slot req_header[15:8]. A slot number of NUM_SLOTS or above latches all zeros. The state then moves to CHECK.
- CHECK lasts exactly one cycle and selects the error code:
  - version != PROTOCOL_VERSION → code 8'h02 (UnsupportedProtocol).
  - Otherwise, msg type != 8'h83, or slot >= NUM_SLOTS, or slot_populated[slot] == 0 → code 8'h01 (InvalidRequest).
  - Otherwise no error.
  - The state then moves to SEND with byte index 0.
- Valid response, 8+HASH_BYTES+NONCE_BYTES bytes (72 by default), in order:
  - PROTOCOL_VERSION, 8'h03, slot, slot_populated zero-extended to 8 bits.
  - PROTOCOL_VERSION (min), PROTOCOL_VERSION (max), CAPABILITIES, 8'h00.
  - Hash bytes, MSB first.
  - Nonce bytes, MSB first.
- ERROR response, 4 bytes: PROTOCOL_VERSION, 8'h7F, error code, 8'h00.
- The byte index advances only on tx_valid && tx_ready. On the handshake of the last byte the state returns to IDLE.
- err_count increments by 1 on the last-byte handshake of an ERROR message and saturates at 255.
- Slot index arithmetic is done at 8-bit width. The slot-range comparison is made before indexing slot_populated.

## Timing
- Reset values: state IDLE, req_ready=1, tx_valid=0, tx_data=0, tx_last=0, tx_is_error=0, err_count=0.
- Latency: request accepted at cycle T → first byte presented with tx_valid=1 at T+2.
- With tx_ready held at 1: last byte at T+1+N (N = message length); req_ready=1 again at T+2+N.
- Stall: while tx_valid && !tx_ready, tx_data, tx_last and tx_is_error hold their values. tx_valid never drops mid-message.
- tx_is_error is constant for the whole message.
- tx_last = 1 only on byte N-1.
- req_valid is ignored outside IDLE. A request held through a busy period is accepted in the first IDLE cycle.
- Back-to-back: in the cycle the last byte is accepted, req_ready=0. The next request can be accepted in the following cycle.
- Input changes after acceptance have no effect on the message in flight.
- Reset mid-message: the engine is in IDLE the next cycle. tx_valid drops without a tx_last, and err_count clears.
- Reset has priority over a simultaneous request handshake.

## Test plan
- Valid request: header 32'h01_83_02_00, slot_populated=8'h05, hash slot 2 = 32 × 8'hA5, nonce = 0x00..0x1F, tx_ready=1 → 72 bytes: 01 03 02 05 01 01 01 00, 32 × A5, 00..1F. tx_last on byte 71, first byte at T+2.
- Version mismatch: header 32'h02_83_00_00 → 4 bytes 01 7F 02 00, tx_is_error=1, err_count becomes 1.
- Unpopulated or out-of-range slot: slot 1 with slot_populated=8'h01, then slot 9 → two ERROR messages with code 01; err_count=2.
- Backpressure: toggle tx_ready pseudo-randomly during a valid response → identical byte sequence, outputs stable while stalled, req_ready=0 throughout.
- Reset at byte 10 of a response → IDLE next cycle, tx_valid=0, err_count=0. A new request afterwards produces a complete correct response.
- Saturation: 260 bad requests → err_count stops at 255.
